wb_dds_source: RTL and testbench
================================

Name: wb_dds_source

Overview:
Wishbone-programmable direct-digital-synthesis sample source that sits directly upstream of signal_generator. It generates the digital waveform that signal_generator converts and drives out on io_analog. Caravel management SoC programs it through the user-project Wishbone slave port. It emits one DW-bit sample per programmed sample period over a valid/ready handshake.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base; decoded on adr[31:8]
DW, 10, sample width in bits
CNT_W, 16, width of the sample-rate divider

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  asynchronous active-high reset
wbs_cyc_i  input  1  Wishbone cycle
wbs_stb_i  input  1  Wishbone strobe
wbs_we_i  input  1  Wishbone write enable
wbs_sel_i  input  4  byte enables
wbs_adr_i  input  32  byte address
wbs_dat_i  input  32  write data
wbs_dat_o  output  32  read data
wbs_ack_o  output  1  Wishbone acknowledge
sample_o  output  DW  unsigned sample to signal_generator
sample_valid_o  output  1  sample_o holds an unconsumed sample
sample_ready_i  input  1  signal_generator accepts sample this cycle

Behaviour:
- Reset (async, wb_rst_i=1): all registers 0 except AMP=8'hFF; wbs_ack_o=0, wbs_dat_o=0, sample_o=0, sample_valid_o=0, phase=0, divider count=0.
- Wishbone access: hit = cyc&stb&(adr[31:8]==BASE_ADDR[31:8])&!ack. On hit, wbs_ack_o=1 for exactly one cycle, the cycle after the request. Back-to-back strobes get ack every other cycle.
- Writes commit on the ack cycle under wbs_sel_i byte masks. Reads return data registered with ack; wbs_dat_o=0 when not acking.
- Unmapped offsets inside the window: ack, read 0, writes ignored. Addresses outside the window: no ack.
- Register map (offset adr[7:2]):
  - 0x00 CTRL: [0] enable, [2:1] wave, [3] clr_ovr (self-clearing, reads 0), [4] phase_rst (self-clearing, reads 0).
  - 0x04 FTW: [31:0] phase increment.
  - 0x08 DIV: [CNT_W-1:0] sample-period minus one.
  - 0x0C AMP: [7:0] amplitude.
  - 0x10 STATUS (RO): [0] enable, [1] overrun sticky, [31:16] overrun count, saturating at 16'hFFFF.
  - 0x14 PHASE (RO): accumulator.
- Divider: with enable=1, cnt increments each cycle. When cnt>=DIV, a tick fires and cnt returns to 0. DIV=0 gives a tick every cycle. With enable=0, cnt is held at 0, no ticks occur, and the phase is held. A pending sample stays valid.
- Tick: the sample is computed from the current phase (pre-increment), then phase <= phase+FTW mod 2^32.
  - A new FTW is used from the next tick.
  - phase_rst forces phase to 0 in its write-commit cycle and overrides a same-cycle tick increment.
- Waveform: p = phase[31:32-DW]; t = phase[31:31-DW].
  - wave 0 saw: p.
  - wave 1 triangle: t[DW] ? ~t[DW-1:0] : t[DW-1:0].
  - wave 2 square: phase[31] ? all-ones : 0.
  - wave 3 DC: all-ones.
- Scaling: sample = (w*(AMP+1))>>8, using a DW+9-bit intermediate. AMP=FF passes the wave unchanged; AMP=00 gives w>>8.
- Output handshake: a transfer occurs when sample_valid_o & sample_ready_i.
  - At a tick, if the output register is empty or transferring this cycle, it loads the new sample and sample_valid_o=1 next cycle. Latency is tick cycle + 1.
  - At a tick with valid & !ready: the new sample is dropped, sample_o is unchanged, overrun<=1, and the count increments.
  - Transfer with no tick: valid<=0 next cycle.
  - sample_o is stable while valid & !ready.
- clr_ovr clears the sticky flag and the count. A same-cycle overrun event wins: the flag becomes 1 and the count becomes 1.
- Reset mid-operation returns every value to its reset state immediately; no partial Wishbone ack is issued.

Test Plan:
- Reset then read all offsets -> CTRL=0, FTW=0, DIV=0, AMP=0xFF, STATUS=0, PHASE=0; each read acked exactly 1 cycle after stb.
- FTW=0x4000_0000, DIV=0, AMP=FF, wave=saw, enable, ready=1 -> samples 0x000, 0x100, 0x200, 0x300, 0x000 on consecutive cycles, first valid 2 cycles after the CTRL write ack.
- DIV=3, FTW=0x8000_0000, wave=square -> valid every 4 cycles alternating 0x000/0x3FF; AMP=0x7F gives 0x1FF instead of 0x3FF.
- ready=0, DIV=0, enable for 10 cycles -> sample_o frozen at first sample, STATUS[1]=1, STATUS[31:16]=9; writing CTRL with clr_ovr=1 while disabled clears both to 0.
- Write FTW with sel=4'b0001, data 0xFFFF_FFFF -> FTW reads 0x0000_00FF; write at BASE+0x40 -> acked, no state change, reads 0.
- Assert wb_rst_i mid-stream with valid=1 -> sample_valid_o and wbs_ack_o drop the same cycle, all registers return to reset values.

Source files
------------

// File: rtl/wb_dds_source.sv
// wb_dds_source: Wishbone-programmed DDS sample source with valid/ready output
module wb_dds_source #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DW        = 10,
  parameter int          CNT_W     = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic [31:0]   wbs_dat_o,
  output logic          wbs_ack_o,
  output logic [DW-1:0] sample_o,
  output logic          sample_valid_o,
  input  logic          sample_ready_i
);
  logic             ack_q, ack_d, enable_q, enable_d, ovr_q, ovr_d, valid_q, valid_d;
  logic [31:0]      dat_q, dat_d, ftw_q, ftw_d, phase_q, phase_d;
  logic [1:0]       wave_q, wave_d;
  logic [CNT_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [7:0]       amp_q, amp_d;
  logic [15:0]      ovr_cnt_q, ovr_cnt_d;
  logic [DW-1:0]    sample_q, sample_d;
  logic             win, hit, wr, ctrl_wr, clr, prst, tick, xfer, load, ovf, unused;
  logic [5:0]       off;
  logic [31:0]      rdata, bmask, div_m;
  logic [DW-1:0]    p, wv;
  logic [DW:0]      t;
  logic [8:0]       amp1;
  logic [DW+8:0]    prod;
  // Bus decode, register writes, divider, phase accumulator, waveform and output stage
  always_comb begin
    win = wbs_adr_i[31:8] == BASE_ADDR[31:8];
    off = wbs_adr_i[7:2];
    hit = wbs_cyc_i && wbs_stb_i && win && !ack_q;
    wr = ack_q && wbs_cyc_i && wbs_stb_i && wbs_we_i && win;
    bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    ctrl_wr = wr && off == 6'd0 && wbs_sel_i[0];
    clr = ctrl_wr && wbs_dat_i[3];
    prst = ctrl_wr && wbs_dat_i[4];
    rdata = off == 6'd0 ? {29'd0, wave_q, enable_q} :
            off == 6'd1 ? ftw_q :
            off == 6'd2 ? 32'(div_q) :
            off == 6'd3 ? {24'd0, amp_q} :
            off == 6'd4 ? {ovr_cnt_q, 14'd0, ovr_q, enable_q} :
            off == 6'd5 ? phase_q : 32'd0;
    ack_d = hit;
    dat_d = (hit && !wbs_we_i) ? rdata : 32'd0;
    enable_d = ctrl_wr ? wbs_dat_i[0] : enable_q;
    wave_d = ctrl_wr ? wbs_dat_i[2:1] : wave_q;
    ftw_d = (wr && off == 6'd1) ? ((ftw_q & ~bmask) | (wbs_dat_i & bmask)) : ftw_q;
    div_m = (wr && off == 6'd2) ? ((32'(div_q) & ~bmask) | (wbs_dat_i & bmask)) : 32'(div_q);
    div_d = div_m[CNT_W-1:0];
    amp_d = (wr && off == 6'd3 && wbs_sel_i[0]) ? wbs_dat_i[7:0] : amp_q;
    tick = enable_q && (cnt_q >= div_q);
    cnt_d = (enable_q && !tick) ? cnt_q + CNT_W'(1) : '0;
    phase_d = prst ? 32'd0 : tick ? phase_q + ftw_q : phase_q;
    p = phase_q[31:32-DW];
    t = phase_q[31:31-DW];
    wv = wave_q == 2'd0 ? p :
         wave_q == 2'd1 ? (t[DW] ? ~t[DW-1:0] : t[DW-1:0]) :
         wave_q == 2'd2 ? {DW{phase_q[31]}} : {DW{1'b1}};
    amp1 = {1'b0, amp_q} + 9'd1;
    prod = (DW+9)'(wv) * (DW+9)'(amp1);
    xfer = valid_q && sample_ready_i;
    load = tick && (!valid_q || xfer);
    ovf = tick && valid_q && !sample_ready_i;
    sample_d = load ? prod[DW+7:8] : sample_q;
    valid_d = load || (valid_q && !xfer);
    ovr_d = ovf || (ovr_q && !clr);
    ovr_cnt_d = clr ? 16'(ovf) : (ovf && ovr_cnt_q != 16'hFFFF) ? ovr_cnt_q + 16'd1 : ovr_cnt_q;
    unused = &{1'b0, wbs_adr_i[1:0], div_m[31:CNT_W], prod[DW+8], prod[7:0]};
  end
  // State registers; reset clears everything except the amplitude, which defaults to full scale
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      enable_q <= 1'b0;
      wave_q <= '0;
      ftw_q <= '0;
      div_q <= '0;
      amp_q <= 8'hFF;
      cnt_q <= '0;
      phase_q <= '0;
      sample_q <= '0;
      valid_q <= 1'b0;
      ovr_q <= 1'b0;
      ovr_cnt_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      enable_q <= enable_d;
      wave_q <= wave_d;
      ftw_q <= ftw_d;
      div_q <= div_d;
      amp_q <= amp_d;
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      sample_q <= sample_d;
      valid_q <= valid_d;
      ovr_q <= ovr_d;
      ovr_cnt_q <= ovr_cnt_d;
    end
  end
  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign sample_o = sample_q;
  assign sample_valid_o = valid_q;
endmodule

// File: tb/tb_wb_dds_source.sv
// tb_wb_dds_source: scoreboard bench for the Wishbone DDS sample source
module tb_wb_dds_source;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack, valid, ready = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_i = 32'h0, dat_o;
  logic [9:0]  sample, exp_v;
  int          errors = 0, checks = 0, cyc_n = 0;
  logic [9:0]  exp_q[$];
  int          xfer_q[$];
  bit          sb_on = 1'b0;

  wb_dds_source dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_dat_o(dat_o), .wbs_ack_o(ack),
    .sample_o(sample), .sample_valid_o(valid), .sample_ready_i(ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  // Scoreboard: every transfer while enabled pops one expected sample
  always @(negedge clk) begin
    if (sb_on && !rst && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got sample %h, none expected", sample);
      end else begin
        exp_v = exp_q.pop_front();
        if (sample !== exp_v) begin
          errors++;
          $display("FAIL sb_sample: got %h expected %h", sample, exp_v);
        end
        xfer_q.push_back(cyc_n);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] r, output int lat, output logic got);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s; lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ack && lat < 8);
    got = ack;
    r = dat_o;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; int lat; logic got;
    wb_xfer(1'b1, a, d, s, r, lat, got);
    checks++;
    if (!got) begin errors++; $display("FAIL wb_write_timeout: addr %h got no ack", a); end
  endtask

  task automatic wait_drain(input int budget, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    sb_on = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain_timeout: %0d samples missing", exp_q.size()); end
  endtask

  task automatic test_reset;
    logic [31:0] exp_r[6] = '{32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0};
    logic [31:0] r; int lat; logic got;
    repeat (2) @(posedge clk); #1;
    checks++; if (valid !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL rst_out: valid=%b ack=%b expected 0 0", valid, ack); end
    checks++; if (sample !== 10'h0 || dat_o !== 32'h0) begin errors++; $display("FAIL rst_data: sample=%h dat=%h expected 0 0", sample, dat_o); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_xfer(1'b0, BASE + 32'(i * 4), 32'h0, 4'hF, r, lat, got);
      checks++; if (r !== exp_r[i]) begin errors++; $display("FAIL rst_reg%0d: read %h expected %h", i, r, exp_r[i]); end
      checks++; if (lat != 1) begin errors++; $display("FAIL rst_ack_lat%0d: %0d cycles expected 1", i, lat); end
      checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack_len%0d: ack=%b expected 0", i, ack); end
    end
  endtask

  task automatic test_saw;
    int n;
    ready = 1'b1;
    wb_write(BASE + 32'h04, 32'h4000_0000, 4'hF);
    wb_write(BASE + 32'h08, 32'h0, 4'hF);
    wb_write(BASE + 32'h00, 32'h10, 4'hF);
    exp_q = '{10'h000, 10'h100, 10'h200, 10'h300, 10'h000};
    xfer_q.delete();
    sb_on = 1'b1;
    wb_write(BASE + 32'h00, 32'h01, 4'hF);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL saw_early: valid=%b expected 0", valid); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL saw_latency: valid=%b expected 1", valid); end
    wait_drain(20, n);
    checks++; if (n != 5) begin errors++; $display("FAIL saw_rate: %0d cycles expected 5", n); end
    for (int i = 1; i < xfer_q.size(); i++) begin
      checks++; if (xfer_q[i] - xfer_q[i-1] != 1) begin errors++; $display("FAIL saw_gap: %0d expected 1", xfer_q[i] - xfer_q[i-1]); end
    end
    wb_write(BASE + 32'h00, 32'h00, 4'hF);
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic test_square;
    int n;
    wb_write(BASE + 32'h04, 32'h8000_0000, 4'hF);
    wb_write(BASE + 32'h08, 32'h3, 4'hF);
    for (int k = 0; k < 2; k++) begin
      wb_write(BASE + 32'h0C, k == 0 ? 32'hFF : 32'h7F, 4'hF);
      wb_write(BASE + 32'h00, 32'h14, 4'hF);
      exp_q = k == 0 ? '{10'h000, 10'h3FF, 10'h000, 10'h3FF} : '{10'h000, 10'h1FF, 10'h000, 10'h1FF};
      xfer_q.delete();
      sb_on = 1'b1;
      wb_write(BASE + 32'h00, 32'h05, 4'hF);
      wait_drain(40, n);
      for (int i = 1; i < xfer_q.size(); i++) begin
        checks++; if (xfer_q[i] - xfer_q[i-1] != 4) begin errors++; $display("FAIL sq_gap%0d: %0d expected 4", k, xfer_q[i] - xfer_q[i-1]); end
      end
      wb_write(BASE + 32'h00, 32'h04, 4'hF);
      repeat (6) @(posedge clk); #1;
    end
    wb_write(BASE + 32'h0C, 32'hFF, 4'hF);
  endtask

  task automatic test_overrun;
    logic [31:0] r; int lat; logic got;
    ready = 1'b0;
    wb_write(BASE + 32'h04, 32'h0100_0000, 4'hF);
    wb_write(BASE + 32'h08, 32'h0, 4'hF);
    wb_write(BASE + 32'h00, 32'h16, 4'hF);
    wb_write(BASE + 32'h00, 32'h07, 4'hF);
    repeat (8) @(posedge clk); #1;
    wb_write(BASE + 32'h00, 32'h06, 4'hF);
    checks++; if (valid !== 1'b1 || sample !== 10'h3FF) begin errors++; $display("FAIL ovr_hold: valid=%b sample=%h expected 1 3ff", valid, sample); end
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, r, lat, got);
    checks++; if (r !== 32'h0009_0002) begin errors++; $display("FAIL ovr_status: read %h expected 00090002", r); end
    wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, r, lat, got);
    checks++; if (r !== 32'h0A00_0000) begin errors++; $display("FAIL ovr_phase: read %h expected 0a000000", r); end
    wb_write(BASE + 32'h00, 32'h08, 4'hF);
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, r, lat, got);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ovr_clear: read %h expected 0", r); end
    wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, r, lat, got);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ctrl_selfclr: read %h expected 0", r); end
    checks++; if (valid !== 1'b1 || sample !== 10'h3FF) begin errors++; $display("FAIL ovr_stable: valid=%b sample=%h expected 1 3ff", valid, sample); end
    ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: valid=%b expected 0", valid); end
  endtask

  task automatic test_bytes_window;
    logic [31:0] r; int lat; logic got;
    wb_write(BASE + 32'h04, 32'h0, 4'hF);
    wb_write(BASE + 32'h04, 32'hFFFF_FFFF, 4'b0001);
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, r, lat, got);
    checks++; if (r !== 32'h0000_00FF) begin errors++; $display("FAIL sel_ftw: read %h expected 000000ff", r); end
    wb_xfer(1'b1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, r, lat, got);
    checks++; if (got !== 1'b1 || lat != 1) begin errors++; $display("FAIL unmapped_ack: got=%b lat=%0d expected 1 1", got, lat); end
    wb_xfer(1'b0, BASE + 32'h40, 32'h0, 4'hF, r, lat, got);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL unmapped_read: read %h expected 0", r); end
    wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, r, lat, got);
    checks++; if (r !== 32'h0000_00FF) begin errors++; $display("FAIL unmapped_side: ftw %h expected 000000ff", r); end
    wb_xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF, r, lat, got);
    checks++; if (r !== 32'hFF) begin errors++; $display("FAIL unmapped_amp: amp %h expected ff", r); end
    wb_xfer(1'b1, BASE + 32'h100, 32'h1, 4'hF, r, lat, got);
    checks++; if (got !== 1'b0) begin errors++; $display("FAIL outside_ack: got=%b expected 0", got); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_r[6] = '{32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0};
    logic [31:0] r; int lat; logic got;
    ready = 1'b0;
    wb_write(BASE + 32'h04, 32'h1234_5678, 4'hF);
    wb_write(BASE + 32'h00, 32'h07, 4'hF);
    repeat (3) @(posedge clk); #1;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_pre: valid=%b expected 1", valid); end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_ack: ack=%b expected 1", ack); end
    #1 rst = 1'b1;
    #1;
    checks++; if (ack !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL mid_async: ack=%b valid=%b expected 0 0", ack, valid); end
    checks++; if (sample !== 10'h0 || dat_o !== 32'h0) begin errors++; $display("FAIL mid_data: sample=%h dat=%h expected 0 0", sample, dat_o); end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_xfer(1'b0, BASE + 32'(i * 4), 32'h0, 4'hF, r, lat, got);
      checks++; if (r !== exp_r[i]) begin errors++; $display("FAIL mid_reg%0d: read %h expected %h", i, r, exp_r[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_saw;
    test_square;
    test_overrun;
    test_bytes_window;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
